velocity_digit_server: RTL and testbench

Converts both cars' signed fixed-point velocities into decimal display digits once per frame, and answers per-pixel digit lookups from the status-bar renderer. The physics side writes velocities and the renderer reads digits; this block is the reading end of the velocity display path.

- Conversion is an iterative binary-to-BCD (double-dabble) engine.
- Results are double-buffered, so the renderer never sees a half-updated value within a frame.

---
 rtl/velocity_digit_server.sv | 185 ++++++++++++++++++
 tb/tb_velocity_digit_server.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/velocity_digit_server.sv
// Converts both cars' signed velocities to three BCD display digits once per frame and
// serves per-pixel digit lookups from a double-buffered active bank.
module velocity_digit_server #(
  parameter int unsigned VEL_WIDTH   = 10,
  parameter logic [3:0]  DIGIT_BLANK = 4'hF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_frame_start,
  input  logic [VEL_WIDTH-1:0] i_car1_vel,
  input  logic [VEL_WIDTH-1:0] i_car2_vel,
  input  logic                 i_req_valid,
  input  logic                 i_req_car,
  input  logic [1:0]           i_req_digit,
  output logic                 o_rsp_valid,
  output logic [3:0]           o_rsp_digit,
  output logic                 o_busy,
  output logic                 o_update
);

  localparam int unsigned CntWidth = $clog2(VEL_WIDTH + 1);
  localparam logic [CntWidth-1:0] LastShift = CntWidth'(VEL_WIDTH - 1);

  localparam logic [1:0] DigHundred = 2'd0;
  localparam logic [1:0] DigTen     = 2'd1;
  localparam logic [1:0] DigOne     = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad1,
    StShift1,
    StStore1,
    StLoad2,
    StShift2,
    StStore2,
    StCommit
  } state_e;

  state_e               state_q, state_d;
  logic [VEL_WIDTH-1:0] vel1_q, vel1_d;
  logic [VEL_WIDTH-1:0] vel2_q, vel2_d;
  logic [VEL_WIDTH-1:0] mag_q, mag_d;
  logic [11:0]          bcd_q, bcd_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [11:0]          shadow1_q, shadow1_d;
  logic [11:0]          shadow2_q, shadow2_d;
  logic [11:0]          active1_q, active1_d;
  logic [11:0]          active2_q, active2_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [3:0]           rsp_digit_q, rsp_digit_d;
  logic                 update_q, update_d;

  // Two's-complement magnitude; the most negative value maps to its unsigned magnitude.
  function automatic logic [VEL_WIDTH-1:0] abs_mag(input logic [VEL_WIDTH-1:0] v);
    return v[VEL_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
    logic [11:0] r;
    logic [3:0]  nib;
    r = b;
    for (int i = 0; i < 3; i++) begin
      nib = b[i*4 +: 4];
      if (nib >= 4'd5) begin
        r[i*4 +: 4] = nib + 4'd3;
      end
    end
    return r;
  endfunction

  logic [11:0] bcd_adj;
  assign bcd_adj = dabble_adjust(bcd_q);

  always_comb begin
    state_d   = state_q;
    vel1_d    = vel1_q;
    vel2_d    = vel2_q;
    mag_d     = mag_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    shadow1_d = shadow1_q;
    shadow2_d = shadow2_q;
    active1_d = active1_q;
    active2_d = active2_q;
    update_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_frame_start) begin
          vel1_d  = i_car1_vel;
          vel2_d  = i_car2_vel;
          state_d = StLoad1;
        end
      end
      StLoad1, StLoad2: begin
        mag_d   = abs_mag((state_q == StLoad1) ? vel1_q : vel2_q);
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = (state_q == StLoad1) ? StShift1 : StShift2;
      end
      StShift1, StShift2: begin
        bcd_d = {bcd_adj[10:0], mag_q[VEL_WIDTH-1]};
        mag_d = {mag_q[VEL_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastShift) begin
          state_d = (state_q == StShift1) ? StStore1 : StStore2;
        end
      end
      StStore1: begin
        shadow1_d = bcd_q;
        state_d   = StLoad2;
      end
      StStore2: begin
        shadow2_d = bcd_q;
        state_d   = StCommit;
      end
      StCommit: begin
        active1_d = shadow1_q;
        active2_d = shadow2_q;
        update_d  = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Lookups read the active bank as it stood before this edge, so a COMMIT on the same
  // edge is not visible to the request.
  logic [11:0] bank;
  logic [3:0]  dig_h, dig_t, dig_o;
  logic [3:0]  lookup;

  always_comb begin
    bank  = i_req_car ? active2_q : active1_q;
    dig_h = bank[11:8];
    dig_t = bank[7:4];
    dig_o = bank[3:0];
    unique case (i_req_digit)
      DigHundred: lookup = (dig_h == 4'd0) ? DIGIT_BLANK : dig_h;
      DigTen:     lookup = ((dig_h == 4'd0) && (dig_t == 4'd0)) ? DIGIT_BLANK : dig_t;
      DigOne:     lookup = dig_o;
      default:    lookup = DIGIT_BLANK;
    endcase
    rsp_valid_d = i_req_valid;
    rsp_digit_d = i_req_valid ? lookup : 4'd0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      vel1_q      <= '0;
      vel2_q      <= '0;
      mag_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      shadow1_q   <= '0;
      shadow2_q   <= '0;
      active1_q   <= '0;
      active2_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_digit_q <= 4'd0;
      update_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      vel1_q      <= vel1_d;
      vel2_q      <= vel2_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      shadow1_q   <= shadow1_d;
      shadow2_q   <= shadow2_d;
      active1_q   <= active1_d;
      active2_q   <= active2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_digit_q <= rsp_digit_d;
      update_q    <= update_d;
    end
  end

  assign o_busy      = (state_q != StIdle);
  assign o_update    = update_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_digit = rsp_digit_q;

endmodule

// File: tb/tb_velocity_digit_server.sv
// Bench for velocity_digit_server: a per-cycle behavioural model (integer display values,
// frame countdown) plus directed lookups with literal expected digits.
module tb_velocity_digit_server;

  localparam int VelWidth   = 10;
  localparam int ConvCycles = 2 * (1 + VelWidth + 1) + 1;
  localparam int Hund = 0, Ten = 1, One = 2, Bg = 3;
  localparam int Blank = 15;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                frame_start = 1'b0;
  logic [VelWidth-1:0] car1 = '0;
  logic [VelWidth-1:0] car2 = '0;
  logic                req_valid = 1'b0;
  logic                req_car = 1'b0;
  logic [1:0]          req_digit = 2'd0;
  logic                rsp_valid;
  logic [3:0]          rsp_digit;
  logic                busy;
  logic                update;

  velocity_digit_server #(
    .VEL_WIDTH  (VelWidth),
    .DIGIT_BLANK(4'hF)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_start(frame_start),
    .i_car1_vel   (car1),
    .i_car2_vel   (car2),
    .i_req_valid  (req_valid),
    .i_req_car    (req_car),
    .i_req_digit  (req_digit),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_digit  (rsp_digit),
    .o_busy       (busy),
    .o_update     (update)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int busy_total = 0;
  int upd_total = 0;

  // Model state: displayed values as integers and a countdown for the conversion window.
  int m_cnt = 0;
  int m_act1 = 0, m_act2 = 0;
  int m_pend1 = 0, m_pend2 = 0;
  int e_valid = 0, e_digit = 0, e_update = 0;

  function automatic int mabs(input logic [VelWidth-1:0] v);
    int s;
    s = int'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  function automatic int mdig(input int v, input int d);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (d)
      Hund:    return (h == 0) ? Blank : h;
      Ten:     return (h == 0 && t == 0) ? Blank : t;
      One:     return o;
      default: return Blank;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the edge, compare every output, return at negedge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_act1 = 0; m_act2 = 0;
      e_valid = 0; e_digit = 0; e_update = 0;
    end else begin
      e_valid  = int'(req_valid);
      e_digit  = req_valid ? mdig(req_car ? m_act2 : m_act1, int'(req_digit)) : 0;
      e_update = 0;
      if (m_cnt == 0) begin
        if (frame_start) begin
          m_pend1 = mabs(car1);
          m_pend2 = mabs(car2);
          m_cnt   = ConvCycles;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_act1 = m_pend1;
          m_act2 = m_pend2;
          e_update = 1;
        end
      end
    end
    #1;
    check("rsp_valid", int'(rsp_valid), e_valid);
    check("rsp_digit", int'(rsp_digit), e_digit);
    check("update", int'(update), e_update);
    check("busy", int'(busy), int'(m_cnt != 0));
    busy_total += int'(busy);
    upd_total  += int'(update);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int car, input int dig, input int exp);
    req_valid = 1'b1;
    req_car   = car[0];
    req_digit = dig[1:0];
    step();
    check(name, int'(rsp_digit), exp);
    req_valid = 1'b0;
  endtask

  task automatic pulse_frame(input int v1, input int v2);
    car1 = v1[VelWidth-1:0];
    car2 = v2[VelWidth-1:0];
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    if (busy) check("busy_timeout", 1, 0);
  endtask

  task automatic run_frame(input int v1, input int v2);
    pulse_frame(v1, v2);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, u0;
    @(negedge clk);
    repeat (3) step();
    check("reset_busy", int'(busy), 0);
    check("reset_update", int'(update), 0);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_digit", int'(rsp_digit), 0);
    rst = 1'b0;
    step();

    // Post-reset lookups
    lit("post_rst_c1_h", 0, Hund, 15);
    lit("post_rst_c1_t", 0, Ten, 15);
    lit("post_rst_c1_o", 0, One, 0);
    lit("post_rst_c1_bg", 0, Bg, 15);

    // Basic conversion with exact busy length and single update
    b0 = busy_total; u0 = upd_total;
    run_frame(123, -345);
    repeat (2) step();
    check("basic_busy_cycles", busy_total - b0, 25);
    check("basic_update_pulses", upd_total - u0, 1);
    lit("basic_c1_h", 0, Hund, 1);
    lit("basic_c1_t", 0, Ten, 2);
    lit("basic_c1_o", 0, One, 3);
    lit("basic_c2_h", 1, Hund, 3);
    lit("basic_c2_t", 1, Ten, 4);
    lit("basic_c2_o", 1, One, 5);

    // Edge values
    run_frame(-512, 7);
    lit("m512_h", 0, Hund, 5);
    lit("m512_t", 0, Ten, 1);
    lit("m512_o", 0, One, 2);
    lit("p7_h", 1, Hund, 15);
    lit("p7_t", 1, Ten, 15);
    lit("p7_o", 1, One, 7);
    run_frame(40, 100);
    lit("p40_h", 0, Hund, 15);
    lit("p40_t", 0, Ten, 4);
    lit("p40_o", 0, One, 0);
    lit("p100_h", 1, Hund, 1);
    lit("p100_t", 1, Ten, 0);
    lit("p100_o", 1, One, 0);
    run_frame(511, 0);
    lit("p511_h", 0, Hund, 5);
    lit("p511_t", 0, Ten, 1);
    lit("p511_o", 0, One, 1);
    lit("zero_h", 1, Hund, 15);
    lit("zero_t", 1, Ten, 15);
    lit("zero_o", 1, One, 0);

    // Overlapping frame pulse is dropped; mid-conversion lookups see the old bank
    b0 = busy_total; u0 = upd_total;
    pulse_frame(200, -77);
    repeat (4) step();
    pulse_frame(9, 9);
    lit("ovl_mid_c1_h", 0, Hund, 5);
    lit("ovl_mid_c2_o", 1, One, 0);
    lit("ovl_mid_c2_t", 1, Ten, 15);
    wait_idle();
    repeat (2) step();
    check("ovl_busy_cycles", busy_total - b0, 25);
    check("ovl_update_pulses", upd_total - u0, 1);
    lit("ovl_c1_h", 0, Hund, 2);
    lit("ovl_c1_t", 0, Ten, 0);
    lit("ovl_c1_o", 0, One, 0);
    lit("ovl_c2_t", 1, Ten, 7);
    lit("ovl_c2_o", 1, One, 7);

    // Reset mid-conversion
    u0 = upd_total;
    pulse_frame(300, -400);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    repeat (30) step();
    check("midrst_no_update", upd_total - u0, 0);
    lit("midrst_c1_h", 0, Hund, 15);
    lit("midrst_c1_t", 0, Ten, 15);
    lit("midrst_c1_o", 0, One, 0);
    lit("midrst_c2_o", 1, One, 0);
    run_frame(-256, 64);
    lit("after_c1_h", 0, Hund, 2);
    lit("after_c1_t", 0, Ten, 5);
    lit("after_c1_o", 0, One, 6);
    lit("after_c2_h", 1, Hund, 15);
    lit("after_c2_t", 1, Ten, 6);
    lit("after_c2_o", 1, One, 4);

    // Streaming lookups across a COMMIT edge; the per-cycle model checks order and values
    car1 = 10'd987 - 10'd500;
    car2 = 10'd58;
    frame_start = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req_car   = i[0];
      req_digit = 2'(i % 4);
      step();
      frame_start = 1'b0;
    end
    req_valid = 1'b0;
    step();
    lit("stream_c1_h", 0, Hund, 4);
    lit("stream_c1_o", 0, One, 7);
    lit("stream_c2_t", 1, Ten, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
